// File: rtl/rom_loader.sv
// Byte-stream image loader: packs bytes little-endian into DW-bit words and
// writes them from address 0 into a back-pressured memory write port.
module rom_loader #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          dl_valid,
   input  logic [7:0]    dl_data,
   input  logic          dl_last,
   output logic          dl_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic          mem_ready,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic [AW:0]   word_count,
   output logic [7:0]    checksum
);

   localparam int BPW = DW / 8;
   localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lane_q, lane_d;
   logic [DW-1:0] pack_q, pack_d;
   logic [AW:0]   ptr_q, ptr_d;
   logic [7:0]    csum_q, csum_d;
   logic          last_q, last_d;
   logic          ovf_q, ovf_d;
   logic          dl_ready_q, mem_we_q, busy_q, done_q;
   logic          xfer, word_end;

   assign xfer     = dl_valid & dl_ready_q;
   assign word_end = (lane_q == LW'(BPW - 1)) | dl_last;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      pack_d  = pack_q;
      ptr_d   = ptr_q;
      csum_d  = csum_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_LOAD: begin
            if (xfer) begin
               csum_d = csum_q + dl_data;
               for (int i = 0; i < BPW; i++) begin
                  if (lane_q == LW'(i)) pack_d[8*i +: 8] = dl_data;
               end
               lane_d = lane_q + 1'b1;
               if (word_end) begin
                  last_d = dl_last;
                  // The pointer has walked past the top word: image does not fit.
                  if (ptr_q[AW]) begin
                     ovf_d   = 1'b1;
                     lane_d  = '0;
                     pack_d  = '0;
                     state_d = dl_last ? S_DONE : S_DRAIN;
                  end else begin
                     state_d = S_WRITE;
                  end
               end
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               ptr_d   = ptr_q + 1'b1;
               lane_d  = '0;
               pack_d  = '0;
               state_d = last_q ? S_DONE : S_LOAD;
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               csum_d = csum_q + dl_data;
               if (dl_last) state_d = S_DONE;
            end
         end
         default: ;
      endcase
      // start wins over any same-cycle byte transfer or write acceptance
      if (start) begin
         state_d = S_LOAD;
         lane_d  = '0;
         pack_d  = '0;
         ptr_d   = '0;
         csum_d  = '0;
         last_d  = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         lane_q     <= '0;
         pack_q     <= '0;
         ptr_q      <= '0;
         csum_q     <= '0;
         last_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dl_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         pack_q     <= pack_d;
         ptr_q      <= ptr_d;
         csum_q     <= csum_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         dl_ready_q <= (state_d == S_LOAD) || (state_d == S_DRAIN);
         mem_we_q   <= (state_d == S_WRITE);
         busy_q     <= (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_DRAIN);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign dl_ready   = dl_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = ptr_q[AW-1:0];
   assign mem_din    = pack_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = ovf_q;
   assign word_count = ptr_q;
   assign checksum   = csum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader with 16-bit words and a 4-word memory: directed image
// table, hand-written abort/reset sequences and randomized images vs a model.
module tb_rom_loader;

   localparam int AW = 2;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          dl_valid = 1'b0;
   logic [7:0]    dl_data = 8'h00;
   logic          dl_last = 1'b0;
   logic          mem_ready = 1'b0;
   logic          dl_ready, mem_we, busy, done, overflow;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [AW:0]   word_count;
   logic [7:0]    checksum;

   rom_loader #(.AW(AW), .DW(DW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .dl_valid   (dl_valid),
      .dl_data    (dl_data),
      .dl_last    (dl_last),
      .dl_ready   (dl_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_ready  (mem_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count),
      .checksum   (checksum)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0]  n;
      logic [95:0] data;
      logic [1:0]  md;
      logic [2:0]  wc;
      logic [7:0]  cs;
      logic        ovf;
      logic [63:0] words;
      logic [7:0]  cyc;
   } vec_t;

   vec_t        tbl[8];
   logic [7:0]  img[$];
   logic [15:0] cap[4];
   int          nwr, cyc, idx_g, first_we_cycles;
   logic        proto_ok;

   // Drives one image through a fresh start; md: 0 steady, 1 stall first write 3 cycles, 2 random gaps
   task automatic run_image(input int md);
      int          stall;
      logic        prev_hold;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      stall = 0;
      prev_hold = 1'b0;
      pa = '0;
      pd = '0;
      idx_g = 0;
      nwr = 0;
      proto_ok = 1'b1;
      first_we_cycles = 0;
      for (int k = 0; k < 4; k++) cap[k] = 16'h0000;
      @(negedge clock);
      start = 1'b1;
      dl_valid = 1'b0;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 400) begin
         if (md == 2) dl_valid = (idx_g < img.size()) && ($urandom_range(0, 3) != 0);
         else         dl_valid = (idx_g < img.size());
         dl_data = (idx_g < img.size()) ? img[idx_g] : 8'h00;
         dl_last = (idx_g == img.size() - 1);
         case (md)
            1:       mem_ready = !(mem_we && stall < 3);
            2:       mem_ready = ($urandom_range(0, 2) != 0);
            default: mem_ready = 1'b1;
         endcase
         if (mem_we && dl_ready) proto_ok = 1'b0;
         if (prev_hold && (!mem_we || mem_addr !== pa || mem_din !== pd)) proto_ok = 1'b0;
         if (mem_we && nwr == 0) first_we_cycles++;
         if (mem_we && !mem_ready) stall++;
         prev_hold = mem_we && !mem_ready;
         pa = mem_addr;
         pd = mem_din;
         if (mem_we && mem_ready) begin
            if (int'(mem_addr) != nwr || nwr >= 4) proto_ok = 1'b0;
            else cap[nwr] = mem_din;
            nwr++;
         end
         if (dl_valid && dl_ready) idx_g++;
         @(negedge clock);
         cyc++;
      end
      dl_valid = 1'b0;
      dl_last = 1'b0;
   endtask

   task automatic expect_image(input string tag, input logic [2:0] wc, input logic [7:0] cs,
                               input logic ovf, input logic [63:0] words, input int exp_cyc);
      logic bad;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_word_count"}, 64'(word_count), 64'(wc));
      check({tag, "_checksum"}, 64'(checksum), 64'(cs));
      check({tag, "_overflow"}, 64'(overflow), 64'(ovf));
      check({tag, "_writes"}, 64'(nwr), 64'(wc));
      check({tag, "_mem"}, {cap[3], cap[2], cap[1], cap[0]}, words);
      check({tag, "_protocol"}, 64'(proto_ok), 64'd1);
      check({tag, "_consumed"}, 64'(idx_g), 64'(img.size()));
      if (exp_cyc >= 0) check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      bad = 1'b0;
      dl_valid = 1'b1;
      dl_data = 8'hEE;
      repeat (2) begin
         @(negedge clock);
         if (dl_ready || mem_we || !done) bad = 1'b1;
      end
      dl_valid = 1'b0;
      check({tag, "_idle_after_done"}, 64'(bad), 64'd0);
   endtask

   task automatic model(output logic [2:0] wc, output logic [7:0] cs, output logic ovf,
                        output logic [63:0] words);
      int nw;
      nw = (img.size() + 1) / 2;
      cs = 8'h00;
      words = 64'h0;
      foreach (img[i]) begin
         cs = cs + img[i];
         if (i / 2 < 4) words[16*(i/2) + 8*(i%2) +: 8] = img[i];
      end
      wc = (nw > 4) ? 3'd4 : 3'(nw);
      ovf = (nw > 4);
   endtask

   initial begin
      logic [2:0]  m_wc;
      logic [7:0]  m_cs;
      logic        m_ovf;
      logic [63:0] m_words;
      logic        bad;
      vec_t        v;

      //          n      bytes (byte0 in LSBs)                 md    wc    cs     ovf   words                     cycles
      tbl[0] = {4'd3,  96'h332211,                         2'd0, 3'd2, 8'h66, 1'b0, 64'h0000_0000_0033_2211, 8'd5};
      tbl[1] = {4'd1,  96'hA5,                             2'd0, 3'd1, 8'hA5, 1'b0, 64'h0000_0000_0000_00A5, 8'd2};
      tbl[2] = {4'd2,  96'h0201,                           2'd0, 3'd1, 8'h03, 1'b0, 64'h0000_0000_0000_0201, 8'd3};
      tbl[3] = {4'd8,  96'h0807060504030201,               2'd0, 3'd4, 8'h24, 1'b0, 64'h0807_0605_0403_0201, 8'd12};
      tbl[4] = {4'd9,  96'h090807060504030201,             2'd0, 3'd4, 8'h2D, 1'b1, 64'h0807_0605_0403_0201, 8'd13};
      tbl[5] = {4'd10, 96'h0A090807060504030201,           2'd0, 3'd4, 8'h37, 1'b1, 64'h0807_0605_0403_0201, 8'd14};
      tbl[6] = {4'd11, 96'h0B0A090807060504030201,         2'd0, 3'd4, 8'h42, 1'b1, 64'h0807_0605_0403_0201, 8'd15};
      tbl[7] = {4'd3,  96'h332211,                         2'd1, 3'd2, 8'h66, 1'b0, 64'h0000_0000_0033_2211, 8'd8};

      repeat (2) @(negedge clock);
      check("reset_outputs", 64'({dl_ready, mem_we, busy, done, overflow, word_count, checksum, mem_addr, mem_din}), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int t = 0; t < 8; t++) begin
         v = tbl[t];
         img.delete();
         for (int i = 0; i < int'(v.n); i++) img.push_back(v.data[8*i +: 8]);
         run_image(int'(v.md));
         expect_image($sformatf("vec%0d", t), v.wc, v.cs, v.ovf, v.words, int'(v.cyc));
         if (v.md == 2'd1) check($sformatf("vec%0d_held_write_cycles", t), 64'(first_we_cycles), 64'd4);
      end

      // Abort during a held write of the second word
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_ready", 64'({dl_ready, busy}), 64'b11);
      dl_valid = 1'b1;
      dl_last = 1'b0;
      dl_data = 8'h01;
      mem_ready = 1'b1;
      @(negedge clock);
      dl_data = 8'h02;
      @(negedge clock);
      dl_data = 8'h03;
      check("we_latency", 64'({mem_we, dl_ready, mem_din}), 64'({2'b10, 16'h0201}));
      @(negedge clock);
      check("ready_after_write", 64'({mem_we, dl_ready, word_count}), 64'({2'b01, 3'd1}));
      @(negedge clock);
      dl_data = 8'h04;
      @(negedge clock);
      mem_ready = 1'b0;
      dl_valid = 1'b0;
      check("second_write", 64'({mem_we, mem_addr, mem_din}), 64'({1'b1, 2'd1, 16'h0403}));
      repeat (2) @(negedge clock);
      check("held_write", 64'({mem_we, mem_addr, mem_din, checksum}), 64'({1'b1, 2'd1, 16'h0403, 8'h0A}));
      start = 1'b1;
      mem_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("abort_state", 64'({mem_we, dl_ready, busy, done, overflow, word_count, checksum}),
            64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00}));
      dl_valid = 1'b1;
      dl_data = 8'hAA;
      @(negedge clock);
      dl_data = 8'hBB;
      dl_last = 1'b1;
      @(negedge clock);
      dl_valid = 1'b0;
      dl_last = 1'b0;
      check("restart_addr0", 64'({mem_we, mem_addr, mem_din}), 64'({1'b1, 2'd0, 16'hBBAA}));
      @(negedge clock);
      check("restart_done", 64'({done, word_count, checksum}), 64'({1'b1, 3'd1, 8'h65}));

      // Randomized images with gaps and back-pressure against the model
      for (int r = 0; r < 40; r++) begin
         img.delete();
         for (int i = 0; i < int'($urandom_range(1, 14)); i++) img.push_back(8'($urandom));
         model(m_wc, m_cs, m_ovf, m_words);
         run_image(2);
         expect_image($sformatf("rnd%0d", r), m_wc, m_cs, m_ovf, m_words, -1);
      end

      // Asynchronous reset in the middle of a load
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dl_valid = 1'b1;
      dl_data = 8'h77;
      mem_ready = 1'b1;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_outputs", 64'({dl_ready, mem_we, busy, done, overflow, word_count, checksum, mem_addr, mem_din}), 64'd0);
      dl_data = 8'h78;
      dl_last = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (mem_we || dl_ready || busy || done) bad = 1'b1;
      end
      dl_valid = 1'b0;
      dl_last = 1'b0;
      check("no_activity_after_reset", 64'(bad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
